// File: rtl/doppio_pkg.sv
// doppio_pkg -- shared definitions for the stream serializer.
//   STREAM_W       : default bits per stream word
//   stream_word_t  : one stream word, bit 0 is the first bit put on the wire
//   ser_state_e    : serializer FSM states (IDLE, SHIFT)
//   ptr_width()    : pointer width for a buffer of n entries (never zero)
package doppio_pkg;

  localparam int STREAM_W = 64;

  typedef logic [0:STREAM_W-1] stream_word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // A one-entry buffer still needs a 1-bit pointer to keep the vectors legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_serializer_word_fifo.sv
// word_fifo -- small FIFO of stream words between the upstream stage and the
// serializer. Head word is readable combinationally so the serializer can load
// it on the same edge it pops, keeping words back-to-back on the wire.
// Ports:
//   clk, srst        : clock, synchronous active-high reset (pointers, count)
//   push, push_data  : write push_data at the tail (ignored when full)
//   pop              : drop the head word (ignored when empty)
//   head_data        : current head word
//   count            : number of stored words, 0..DEPTH
//   full, empty      : count == DEPTH, count == 0
module word_fifo
  import doppio_pkg::*;
#(
  parameter int WORD_W = STREAM_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              push,
  input  logic [0:WORD_W-1] push_data,
  input  logic              pop,
  output logic [0:WORD_W-1] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [0:WORD_W-1] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/stream_serializer.sv
// stream_serializer -- buffers stream words and shifts them out one bit per
// cycle, IN[0] first, with no gap between consecutive buffered words.
// Ports:
//   D_CLK            : clock, all state on the rising edge
//   D_RST            : synchronous active-high reset, overrides everything
//   D_OFF            : pause; freezes the shifter, the buffer keeps accepting
//   IN, IN_VALID     : upstream word and its valid flag
//   IN_READY         : buffer has room this cycle (low during reset)
//   BIT_OUT          : current serial bit (0 while idle)
//   BIT_VALID        : BIT_OUT is consumed at the next edge
//   WORD_DONE        : this cycle carries the last bit of a word
//   LED_0/1/2        : busy, buffer full, toggles once per completed word
module stream_serializer
  import doppio_pkg::*;
#(
  parameter int STREAM_W = doppio_pkg::STREAM_W,
  parameter int DEPTH    = 2
) (
  input  logic                D_CLK,
  input  logic                D_RST,
  input  logic                D_OFF,
  input  logic [0:STREAM_W-1] IN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic                BIT_OUT,
  output logic                BIT_VALID,
  output logic                WORD_DONE,
  output logic                LED_0,
  output logic                LED_1,
  output logic                LED_2
);

  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int BITCNT_W = $clog2(STREAM_W);

  ser_state_e          state_q, state_d;
  logic [0:STREAM_W-1] sreg_q, sreg_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                led2_q, led2_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic [0:STREAM_W-1] fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                bit_valid;
  logic                word_done;

  // Ready depends only on occupancy: a full buffer refuses even on a pop edge.
  assign IN_READY  = !D_RST && (fifo_count < CNT_W'(DEPTH));
  assign fifo_push = IN_VALID && IN_READY;

  word_fifo #(
    .WORD_W (STREAM_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_word_fifo (
    .clk       (D_CLK),
    .srst      (D_RST),
    .push      (fifo_push),
    .push_data (IN),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    led2_d    = led2_q;
    fifo_pop  = 1'b0;
    bit_valid = 1'b0;
    word_done = 1'b0;

    if (state_q == IDLE) begin
      if (!fifo_empty && !D_OFF) begin
        fifo_pop  = 1'b1;
        sreg_d    = fifo_head;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
    end else begin
      bit_valid = !D_OFF;
      word_done = bit_valid && (bit_cnt_q == BITCNT_W'(STREAM_W - 1));
      if (bit_valid) begin
        // Index 0 is the MSB of a [0:W-1] vector, so << moves toward bit 0.
        sreg_d    = sreg_q << 1;
        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
      end
      if (word_done) begin
        led2_d = !led2_q;
        // Chain straight into the next buffered word to avoid a bubble.
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          sreg_d    = fifo_head;
          bit_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge D_CLK) begin
    if (D_RST) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      led2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      led2_q    <= led2_d;
    end
  end

  assign BIT_OUT   = (state_q == SHIFT) ? sreg_q[0] : 1'b0;
  assign BIT_VALID = bit_valid;
  assign WORD_DONE = word_done;
  assign LED_0     = (state_q == SHIFT);
  assign LED_1     = fifo_full;
  assign LED_2     = led2_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: scenario tasks drive stimulus, and a bit-queue
// reference (every accepted word appended IN[0]..IN[W-1], truncated on reset)
// gives the expected serial stream and word boundaries.
module tb_stream_serializer;

  localparam int W = 64;

  logic         clk;
  logic         d_rst, d_off, in_valid;
  logic [0:W-1] in_word;
  logic         in_ready, bit_out, bit_valid, word_done, led0, led1, led2;

  stream_serializer #(.STREAM_W(W), .DEPTH(2)) dut (
    .D_CLK(clk), .D_RST(d_rst), .D_OFF(d_off), .IN(in_word), .IN_VALID(in_valid),
    .IN_READY(in_ready), .BIT_OUT(bit_out), .BIT_VALID(bit_valid), .WORD_DONE(word_done),
    .LED_0(led0), .LED_1(led1), .LED_2(led2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic exp_bits[$];
  logic obs_bits[$];
  logic obs_done[$];
  int   first_cyc, last_cyc, accept_cyc, bits_since_rst;
  int   stray_done, ready_led_bad, idle_out_bad;
  logic last_acc;
  logic s_in_ready, s_bit_out, s_bit_valid, s_word_done, s_led0, s_led1, s_led2;

  // One clock: sample outputs mid-cycle, update the reference, pass the edge.
  task automatic tick();
    @(negedge clk);
    s_in_ready = in_ready; s_bit_out = bit_out; s_bit_valid = bit_valid;
    s_word_done = word_done; s_led0 = led0; s_led1 = led1; s_led2 = led2;
    last_acc = 1'b0;
    if (d_rst) begin
      while (exp_bits.size() > obs_bits.size()) void'(exp_bits.pop_back());
      bits_since_rst = 0;
    end else begin
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        accept_cyc = cyc;
        for (int i = 0; i < W; i++) exp_bits.push_back(in_word[i]);
      end
      if (bit_valid) begin
        obs_bits.push_back(bit_out);
        obs_done.push_back(word_done);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        bits_since_rst++;
      end
      if (word_done && !bit_valid) stray_done++;
      if (led1 === in_ready) ready_led_bad++;
      if (!led0 && bit_out !== 1'b0) idle_out_bad++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    exp_bits.delete(); obs_bits.delete(); obs_done.delete();
    first_cyc = -1; last_cyc = -1;
    stray_done = 0; ready_led_bad = 0; idle_out_bad = 0;
  endtask

  task automatic push_word(input logic [0:W-1] w);
    in_word = w; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (last_acc) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 300 && obs_bits.size() < n; i++) tick();
  endtask

  task automatic drain(input int max);
    in_valid = 1'b0; d_off = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (!s_led0 && !s_bit_valid && obs_bits.size() >= exp_bits.size()) break;
    end
    tick(); tick();
  endtask

  function automatic logic [0:W-1] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    d_rst = 1'b1; d_off = 1'b1; in_valid = 1'b1; in_word = rand_word();
    bits_since_rst = 0;
    clear_obs();
    tick(); tick();
    n_cmp++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_during: got %b want 0", s_in_ready); end
    d_rst = 1'b0; d_off = 1'b0; in_valid = 1'b0;
    tick();
    n_cmp++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", s_in_ready); end
    n_cmp++; if (s_bit_out !== 1'b0) begin n_fail++; $display("FAIL rst_bit_out: got %b want 0", s_bit_out); end
    n_cmp++; if (s_bit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_bit_valid: got %b want 0", s_bit_valid); end
    n_cmp++; if (s_word_done !== 1'b0) begin n_fail++; $display("FAIL rst_word_done: got %b want 0", s_word_done); end
    n_cmp++; if (s_led0 !== 1'b0) begin n_fail++; $display("FAIL rst_led0: got %b want 0", s_led0); end
    n_cmp++; if (s_led1 !== 1'b0) begin n_fail++; $display("FAIL rst_led1: got %b want 0", s_led1); end
    n_cmp++; if (s_led2 !== 1'b0) begin n_fail++; $display("FAIL rst_led2: got %b want 0", s_led2); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (obs_bits.size() !== 0) begin n_fail++; $display("FAIL rst_no_bits: got %0d bits want 0", obs_bits.size()); end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    logic [0:W-1] w;
    int c0;
    w = 64'hA5A5_0000_FFFF_0001;
    clear_obs();
    push_word(w);
    c0 = accept_cyc;
    drain(200);
    n_cmp++; if (obs_bits.size() !== 64) begin n_fail++; $display("FAIL single_len: got %0d want 64", obs_bits.size()); end
    for (int i = 0; i < obs_bits.size() && i < W; i++) begin
      n_cmp++; if (obs_bits[i] !== w[i]) begin n_fail++; $display("FAIL single_bit%0d: got %b want %b", i, obs_bits[i], w[i]); end
      n_cmp++; if (obs_done[i] !== (i == W - 1)) begin n_fail++; $display("FAIL single_done%0d: got %b want %b", i, obs_done[i], i == W - 1); end
    end
    n_cmp++; if (first_cyc !== c0 + 2) begin n_fail++; $display("FAIL single_first_lat: got cyc %0d want %0d", first_cyc, c0 + 2); end
    n_cmp++; if (last_cyc !== c0 + 65) begin n_fail++; $display("FAIL single_last_lat: got cyc %0d want %0d", last_cyc, c0 + 65); end
    n_cmp++; if (stray_done !== 0) begin n_fail++; $display("FAIL single_stray_done: got %0d want 0", stray_done); end
    n_cmp++; if (s_led2 !== 1'b1) begin n_fail++; $display("FAIL single_led2: got %b want 1", s_led2); end
    $display("test_single: word %h, %0d bits, first cyc %0d last cyc %0d", w, obs_bits.size(), first_cyc, last_cyc);
  endtask

  task automatic test_back_to_back();
    logic [0:W-1] w [3];
    int idx;
    clear_obs();
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    idx = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && idx < 3; i++) begin
      in_word = w[idx];
      tick();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %b want 0", s_in_ready); end
    n_cmp++; if (s_led1 !== 1'b1) begin n_fail++; $display("FAIL b2b_led1: got %b want 1", s_led1); end
    drain(400);
    n_cmp++; if (obs_bits.size() !== 3 * W) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", obs_bits.size(), 3 * W); end
    for (int i = 0; i < obs_bits.size() && i < 3 * W; i++) begin
      n_cmp++; if (obs_bits[i] !== w[i / W][i % W]) begin n_fail++; $display("FAIL b2b_bit%0d: got %b want %b", i, obs_bits[i], w[i / W][i % W]); end
      n_cmp++; if (obs_done[i] !== ((i % W) == W - 1)) begin n_fail++; $display("FAIL b2b_done%0d: got %b", i, obs_done[i]); end
    end
    n_cmp++; if (last_cyc - first_cyc + 1 !== 3 * W) begin n_fail++; $display("FAIL b2b_contig: got span %0d want %0d", last_cyc - first_cyc + 1, 3 * W); end
    n_cmp++; if (ready_led_bad !== 0) begin n_fail++; $display("FAIL b2b_ready_vs_led1: got %0d bad cycles want 0", ready_led_bad); end
    n_cmp++; if (s_led2 !== ((bits_since_rst / W) % 2 == 1)) begin n_fail++; $display("FAIL b2b_led2: got %b", s_led2); end
    $display("test_back_to_back: %0d bits over span %0d", obs_bits.size(), last_cyc - first_cyc + 1);
  endtask

  task automatic test_pause();
    logic [0:W-1] w0, w1;
    logic frozen;
    int   acc;
    clear_obs();
    w0 = rand_word(); w1 = rand_word();
    push_word(w0);
    wait_bits(21);
    frozen = exp_bits[21];
    d_off = 1'b1;
    in_word = w1; in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) acc++;
      in_valid = 1'b0;
      n_cmp++; if (s_bit_valid !== 1'b0) begin n_fail++; $display("FAIL pause_valid%0d: got %b want 0", i, s_bit_valid); end
      n_cmp++; if (s_word_done !== 1'b0) begin n_fail++; $display("FAIL pause_done%0d: got %b want 0", i, s_word_done); end
      n_cmp++; if (s_bit_out !== frozen) begin n_fail++; $display("FAIL pause_bit_out%0d: got %b want %b", i, s_bit_out, frozen); end
    end
    n_cmp++; if (acc !== 1) begin n_fail++; $display("FAIL pause_accept: got %0d accepts want 1", acc); end
    drain(300);
    n_cmp++; if (obs_bits.size() !== 2 * W) begin n_fail++; $display("FAIL pause_len: got %0d want %0d", obs_bits.size(), 2 * W); end
    for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++) begin
      n_cmp++; if (obs_bits[i] !== exp_bits[i]) begin n_fail++; $display("FAIL pause_bit%0d: got %b want %b", i, obs_bits[i], exp_bits[i]); end
    end
    n_cmp++; if (last_cyc - first_cyc + 1 !== 2 * W + 10) begin n_fail++; $display("FAIL pause_span: got %0d want %0d", last_cyc - first_cyc + 1, 2 * W + 10); end
    $display("test_pause: %0d bits, span %0d", obs_bits.size(), last_cyc - first_cyc + 1);
  endtask

  task automatic test_off_idle();
    clear_obs();
    d_off = 1'b1;
    push_word(rand_word());
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (s_bit_valid !== 1'b0) begin n_fail++; $display("FAIL offidle_valid%0d: got %b want 0", i, s_bit_valid); end
      n_cmp++; if (s_led0 !== 1'b0) begin n_fail++; $display("FAIL offidle_led0_%0d: got %b want 0", i, s_led0); end
    end
    d_off = 1'b0;
    tick();
    n_cmp++; if (s_bit_valid !== 1'b0) begin n_fail++; $display("FAIL offidle_load: got %b want 0", s_bit_valid); end
    tick();
    n_cmp++; if (s_bit_valid !== 1'b1) begin n_fail++; $display("FAIL offidle_first: got %b want 1", s_bit_valid); end
    drain(200);
    n_cmp++; if (obs_bits.size() !== W) begin n_fail++; $display("FAIL offidle_len: got %0d want %0d", obs_bits.size(), W); end
    for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++) begin
      n_cmp++; if (obs_bits[i] !== exp_bits[i]) begin n_fail++; $display("FAIL offidle_bit%0d: got %b want %b", i, obs_bits[i], exp_bits[i]); end
    end
    $display("test_off_idle: %0d bits", obs_bits.size());
  endtask

  task automatic test_push_on_last();
    clear_obs();
    push_word(rand_word());
    push_word(rand_word());
    wait_bits(W - 1);
    in_word = rand_word(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (s_word_done !== 1'b1) begin n_fail++; $display("FAIL pol_done: got %b want 1", s_word_done); end
    n_cmp++; if (last_acc !== 1'b1) begin n_fail++; $display("FAIL pol_accept: got %b want 1", last_acc); end
    n_cmp++; if (s_led1 !== 1'b0) begin n_fail++; $display("FAIL pol_led1_before: got %b want 0", s_led1); end
    tick();
    n_cmp++; if (s_bit_valid !== 1'b1) begin n_fail++; $display("FAIL pol_no_bubble: got %b want 1", s_bit_valid); end
    n_cmp++; if (s_led1 !== 1'b0) begin n_fail++; $display("FAIL pol_led1_after: got %b want 0", s_led1); end
    drain(400);
    n_cmp++; if (obs_bits.size() !== 3 * W) begin n_fail++; $display("FAIL pol_len: got %0d want %0d", obs_bits.size(), 3 * W); end
    for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++) begin
      n_cmp++; if (obs_bits[i] !== exp_bits[i]) begin n_fail++; $display("FAIL pol_bit%0d: got %b want %b", i, obs_bits[i], exp_bits[i]); end
      n_cmp++; if (obs_done[i] !== ((i % W) == W - 1)) begin n_fail++; $display("FAIL pol_done%0d: got %b", i, obs_done[i]); end
    end
    n_cmp++; if (last_cyc - first_cyc + 1 !== 3 * W) begin n_fail++; $display("FAIL pol_contig: got %0d want %0d", last_cyc - first_cyc + 1, 3 * W); end
    $display("test_push_on_last: %0d bits", obs_bits.size());
  endtask

  task automatic test_reset_mid();
    clear_obs();
    push_word(rand_word());
    push_word(rand_word());
    wait_bits(31);
    d_rst = 1'b1;
    tick();
    n_cmp++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %b want 0", s_in_ready); end
    d_rst = 1'b0;
    tick();
    n_cmp++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", s_in_ready); end
    n_cmp++; if (s_led0 !== 1'b0) begin n_fail++; $display("FAIL rmid_led0: got %b want 0", s_led0); end
    n_cmp++; if (s_bit_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", s_bit_valid); end
    n_cmp++; if (s_led1 !== 1'b0) begin n_fail++; $display("FAIL rmid_led1: got %b want 0", s_led1); end
    n_cmp++; if (s_led2 !== 1'b0) begin n_fail++; $display("FAIL rmid_led2: got %b want 0", s_led2); end
    for (int i = 0; i < 150; i++) tick();
    n_cmp++; if (obs_bits.size() !== 31) begin n_fail++; $display("FAIL rmid_len: got %0d want 31", obs_bits.size()); end
    for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++) begin
      n_cmp++; if (obs_bits[i] !== exp_bits[i]) begin n_fail++; $display("FAIL rmid_bit%0d: got %b want %b", i, obs_bits[i], exp_bits[i]); end
      n_cmp++; if (obs_done[i] !== 1'b0) begin n_fail++; $display("FAIL rmid_done%0d: got %b want 0", i, obs_done[i]); end
    end
    n_cmp++; if (stray_done !== 0) begin n_fail++; $display("FAIL rmid_stray_done: got %0d want 0", stray_done); end
    $display("test_reset_mid: %0d bits before reset", obs_bits.size());
  endtask

  task automatic test_random();
    clear_obs();
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_word  = rand_word();
      d_off    = ($urandom_range(0, 5) == 0);
      tick();
    end
    drain(600);
    n_cmp++; if (obs_bits.size() !== exp_bits.size()) begin n_fail++; $display("FAIL rand_len: got %0d want %0d", obs_bits.size(), exp_bits.size()); end
    for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++) begin
      n_cmp++; if (obs_bits[i] !== exp_bits[i]) begin n_fail++; $display("FAIL rand_bit%0d: got %b want %b", i, obs_bits[i], exp_bits[i]); end
      n_cmp++; if (obs_done[i] !== ((i % W) == W - 1)) begin n_fail++; $display("FAIL rand_done%0d: got %b", i, obs_done[i]); end
    end
    n_cmp++; if (stray_done !== 0) begin n_fail++; $display("FAIL rand_stray_done: got %0d want 0", stray_done); end
    n_cmp++; if (ready_led_bad !== 0) begin n_fail++; $display("FAIL rand_ready_vs_led1: got %0d want 0", ready_led_bad); end
    n_cmp++; if (idle_out_bad !== 0) begin n_fail++; $display("FAIL rand_idle_bit_out: got %0d want 0", idle_out_bad); end
    n_cmp++; if (s_led2 !== ((bits_since_rst / W) % 2 == 1)) begin n_fail++; $display("FAIL rand_led2: got %b", s_led2); end
    $display("test_random: %0d bits, %0d words", obs_bits.size(), obs_bits.size() / W);
  endtask

  initial begin
    d_rst = 1'b1; d_off = 1'b0; in_valid = 1'b0; in_word = '0;
    last_acc = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_pause();
    test_off_idle();
    test_push_on_last();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
